// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
//
// Takes the execute-stage bundle, waits for the data-bus response of any
// load/store issued in execute, aligns and extends load data (merging
// LWL/LWR when enabled), forwards the stage result to decode and registers
// the writeback bundle.
//
// Configuration macro:
//   MEM_STAGE_UNALIGNED_EN  defined   -> LWL/LWR merge with rdata2_i
//                           undefined -> LWL/LWR write ld_raw as a plain LW
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   valid_i .. waddr_i     execute bundle (pc, inst, ctrl, result, eaddr,
//                          old rt value, destination GPR)
//   data_data_ok           data-bus response pulse, one per request, in order
//   data_rdata             read data, valid with data_data_ok
//   ready_i                pipeline advance (all stages done)
//   done_o                 this stage is finished with the current bundle
//   fwd_addr/data/ok       forwarding to decode
//   valid_o .. wen_o       registered writeback bundle
//   state_dbg              current FSM state (IDLE=0, WAIT=1, HOLD=2)
//
// Handshake: the bundle advances on every cycle with ready_i=1. A bundle is
// passed on (valid_o=1) only if valid_i && done_o in that cycle; ready_i while
// !done_o drops the bundle, which is the controller's error and is not masked.
// While !ready_i all registered outputs hold.

`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_LB    2
`define I_LBU   3
`define I_LH    4
`define I_LHU   5
`define I_LW    6
`define I_LWL   7
`define I_LWR   8
`define I_WEX   9
`define I_MAX   10
`endif

module memory_stage #(
  parameter int CTRL_W = `I_MAX
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       eaddr_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        waddr_i,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  input  logic              ready_i,
  output logic              done_o,
  output logic [4:0]        fwd_addr,
  output logic [31:0]       fwd_data,
  output logic              fwd_ok,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic [4:0]        waddr_o,
  output logic [31:0]       wdata_o,
  output logic              wen_o,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic        rbuf_load;
  logic [31:0] rbuf;
  logic        memop;
  logic [31:0] ld_raw;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] final_val;

  assign memop     = valid_i && (ctrl_i[`I_MEM_R] || ctrl_i[`I_MEM_W]);
  assign state_dbg = state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      rbuf  <= 32'd0;
    end else begin
      state <= state_n;
      if (rbuf_load) rbuf <= data_rdata;
    end
  end

  // WAIT/HOLD do not re-check memop: the bundle is stable until ready_i.
  always_comb begin
    state_n   = state;
    rbuf_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (memop) begin
          if (!data_data_ok) begin
            state_n = S_WAIT;
          end else if (!ready_i) begin
            state_n   = S_HOLD;
            rbuf_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (ready_i) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_HOLD;
            rbuf_load = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A response arriving in IDLE without a memop is stale and falls through
  // (done_o is already 1 via !memop).
  assign done_o = !memop || data_data_ok || (state == S_HOLD);

  // ---------------- Load data path ----------------
  assign ld_raw   = (state == S_HOLD) ? rbuf : data_rdata;
  assign off      = eaddr_i[1:0];
  assign byte_sel = 8'(ld_raw >> {off, 3'b000});
  assign half_sel = off[1] ? ld_raw[31:16] : ld_raw[15:0];

`ifdef MEM_STAGE_UNALIGNED_EN
  logic [4:0]  sh_l, sh_r;
  logic [31:0] mask_l, mask_r;
  logic [31:0] lwl_val, lwr_val;

  // 3-off on a 2-bit offset is its bitwise inverse.
  assign sh_l    = {~off, 3'b000};
  assign sh_r    = {off, 3'b000};
  assign mask_l  = 32'hFFFF_FFFF << sh_l;
  assign mask_r  = 32'hFFFF_FFFF >> sh_r;
  assign lwl_val = ((ld_raw << sh_l) & mask_l) | (rdata2_i & ~mask_l);
  assign lwr_val = ((ld_raw >> sh_r) & mask_r) | (rdata2_i & ~mask_r);
`else
  logic unused_merge;
  assign unused_merge = ^{rdata2_i, ctrl_i[`I_LWL], ctrl_i[`I_LWR]};
`endif

  always_comb begin
    load_val = ld_raw;
    if (ctrl_i[`I_LB])       load_val = {{24{byte_sel[7]}}, byte_sel};
    else if (ctrl_i[`I_LBU]) load_val = {24'd0, byte_sel};
    else if (ctrl_i[`I_LH])  load_val = {{16{half_sel[15]}}, half_sel};
    else if (ctrl_i[`I_LHU]) load_val = {16'd0, half_sel};
`ifdef MEM_STAGE_UNALIGNED_EN
    else if (ctrl_i[`I_LWL]) load_val = lwl_val;
    else if (ctrl_i[`I_LWR]) load_val = lwr_val;
`endif
  end

  // LW (and unlisted load variants) take ld_raw via the default above.
  logic unused_bits;
  assign unused_bits = ^{eaddr_i[31:2], ctrl_i[`I_LW]};

  // Stores and non-memory ops write back the execute result.
  assign final_val = ctrl_i[`I_MEM_R] ? load_val : result_i;

  // ---------------- Forwarding ----------------
  assign fwd_addr = {5{valid_i}} & waddr_i;
  assign fwd_data = final_val;
  assign fwd_ok   = valid_i && done_o && ctrl_i[`I_WEX];

  // ---------------- Writeback register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_o <= 1'b0;
      pc_o    <= 32'd0;
      inst_o  <= 32'd0;
      waddr_o <= 5'd0;
      wdata_o <= 32'd0;
      wen_o   <= 1'b0;
    end else if (ready_i) begin
      valid_o <= valid_i && done_o;
      pc_o    <= pc_i;
      inst_o  <= inst_i;
      waddr_o <= waddr_i;
      wdata_o <= final_val;
      wen_o   <= ctrl_i[`I_WEX] && (waddr_i != 5'd0);
    end
  end

endmodule
